bullet_collision_scan: RTL and testbench

Per-frame collision stage, directly downstream of bullet generation/movement. Once per frame tick it latches the current enemy, player and bullet states, scans player bullets against enemies and enemy bullets against the player one pair per cycle, then commits the cleared states and a one-cycle result pulse. Its outputs become the next frame's state inputs to bullet generation and movement.

---
 rtl/game_pkg.sv | 48 ++++
 rtl/aabb_overlap.sv | 32 +++
 rtl/bullet_collision_scan.sv | 218 +++++++++++++++++++++
 tb/tb_bullet_collision_scan.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants, position helpers and FSM state type for the
// per-frame collision stage.
package game_pkg;

  localparam int POS_W = 19;
  localparam int X_MSB = 18;
  localparam int X_LSB = 9;
  localparam int Y_MSB = 8;

  localparam int SCR_W = 640;
  localparam int SCR_H = 480;

  localparam int SZ_W = 6;
  localparam logic [SZ_W-1:0] ENEMY_W  = 6'd32;
  localparam logic [SZ_W-1:0] ENEMY_H  = 6'd24;
  localparam logic [SZ_W-1:0] PLAYER_W = 6'd20;
  localparam logic [SZ_W-1:0] PLAYER_H = 6'd24;
  localparam logic [SZ_W-1:0] BULLET_W = 6'd4;
  localparam logic [SZ_W-1:0] BULLET_H = 6'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PB_SCAN,
    S_EB_SCAN,
    S_DONE
  } scan_state_t;

  function automatic logic [X_MSB-X_LSB:0] pos_x(
    input logic [POS_W-1:0] p
  );
    return p[X_MSB:X_LSB];
  endfunction

  function automatic logic [Y_MSB:0] pos_y(
    input logic [POS_W-1:0] p
  );
    return p[Y_MSB:0];
  endfunction

  function automatic logic off_screen(
    input logic [POS_W-1:0] p
  );
    return (pos_x(p) >= 10'(SCR_W)) ||
           (pos_y(p) >= 9'(SCR_H));
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Combinational strict AABB overlap of two boxes given top-left
// positions and sizes. Ports: i_PosA/i_PosB, i_WA/i_HA/i_WB/i_HB, o_Overlap.
module aabb_overlap
  import game_pkg::*;
(
  input  logic [POS_W-1:0] i_PosA,
  input  logic [POS_W-1:0] i_PosB,
  input  logic [SZ_W-1:0]  i_WA,
  input  logic [SZ_W-1:0]  i_HA,
  input  logic [SZ_W-1:0]  i_WB,
  input  logic [SZ_W-1:0]  i_HB,
  output logic             o_Overlap
);

  // One extra bit so the far edge never wraps.
  logic [10:0] w_ax, w_bx, w_ax_end, w_bx_end;
  logic [9:0]  w_ay, w_by, w_ay_end, w_by_end;

  assign w_ax = {1'b0, pos_x(i_PosA)};
  assign w_bx = {1'b0, pos_x(i_PosB)};
  assign w_ay = {1'b0, pos_y(i_PosA)};
  assign w_by = {1'b0, pos_y(i_PosB)};

  assign w_ax_end = w_ax + {5'd0, i_WA};
  assign w_bx_end = w_bx + {5'd0, i_WB};
  assign w_ay_end = w_ay + {4'd0, i_HA};
  assign w_by_end = w_by + {4'd0, i_HB};

  assign o_Overlap = (w_ax < w_bx_end) && (w_bx < w_ax_end) &&
                     (w_ay < w_by_end) && (w_by < w_ay_end);

endmodule

// File: rtl/bullet_collision_scan.sv
// Per-frame collision scan: latches states on a tick, scans player
// bullets x enemies then enemy bullets x player one pair per cycle,
// and commits cleared states with o_Done/o_PlayerHit pulses.
// Inputs: i_Clk, i_Rst (sync, active-high), i_fFrameTick, state and
// position vectors. Outputs: committed states, o_KillCount,
// o_PlayerHit, o_Busy, o_Done, o_TickDropped.
// Option: define BULLET_CULL_EN to drop off-screen bullets at load.
module bullet_collision_scan
  import game_pkg::*;
#(
  parameter int MAX_ENEMY         = 15,
  parameter int MAX_ENEMY_BULLET  = 31,
  parameter int MAX_PLAYER_BULLET = 15
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic                         i_fFrameTick,
  input  logic [MAX_ENEMY-1:0]         i_EnemyState,
  input  logic [MAX_ENEMY_BULLET-1:0]  i_EnemyBulletState,
  input  logic                         i_PlayerState,
  input  logic [MAX_PLAYER_BULLET-1:0] i_PlayerBulletState,
  input  logic [POS_W-1:0]             i_EnemyPosition [MAX_ENEMY],
  input  logic [POS_W-1:0]             i_EnemyBulletPosition [MAX_ENEMY_BULLET],
  input  logic [POS_W-1:0]             i_PlayerBulletPosition [MAX_PLAYER_BULLET],
  input  logic [POS_W-1:0]             i_PlayerPosition,
  output logic [MAX_ENEMY-1:0]         o_EnemyState,
  output logic [MAX_ENEMY_BULLET-1:0]  o_EnemyBulletState,
  output logic [MAX_PLAYER_BULLET-1:0] o_PlayerBulletState,
  output logic                         o_PlayerState,
  output logic [$clog2(MAX_ENEMY+1)-1:0] o_KillCount,
  output logic                         o_PlayerHit,
  output logic                         o_Busy,
  output logic                         o_Done,
  output logic                         o_TickDropped
);

  localparam int EW = $clog2(MAX_ENEMY + 1);
  localparam int PW = $clog2(MAX_PLAYER_BULLET + 1);
  localparam int BW = $clog2(MAX_ENEMY_BULLET + 1);
  localparam int KW = $clog2(MAX_ENEMY + 1);

  scan_state_t r_state, w_state_nxt;

  logic [MAX_ENEMY-1:0]         r_en;
  logic [MAX_ENEMY_BULLET-1:0]  r_eb;
  logic [MAX_PLAYER_BULLET-1:0] r_pb;
  logic                         r_pl;
  logic [KW-1:0]                r_kill;
  logic                         r_hit;
  logic [EW-1:0]                r_e;
  logic [PW-1:0]                r_p;
  logic [BW-1:0]                r_b;

  logic [MAX_ENEMY-1:0]         r_en_out;
  logic [MAX_ENEMY_BULLET-1:0]  r_eb_out;
  logic [MAX_PLAYER_BULLET-1:0] r_pb_out;
  logic                         r_pl_out;
  logic [KW-1:0]                r_kill_out;
  logic                         r_hit_pls;
  logic                         r_done_pls;
  logic                         r_drop_pls;

  logic [MAX_ENEMY_BULLET-1:0]  w_eb_keep;
  logic [MAX_PLAYER_BULLET-1:0] w_pb_keep;
  logic w_pb_ovl, w_eb_ovl;
  logic w_pb_hit, w_eb_hit;
  logic w_pb_last, w_eb_last;
  logic w_busy;

`ifdef BULLET_CULL_EN
  always_comb begin
    w_pb_keep = '1;
    w_eb_keep = '1;
    for (int i = 0; i < MAX_PLAYER_BULLET; i++)
      if (off_screen(i_PlayerBulletPosition[i]))
        w_pb_keep[i] = 1'b0;
    for (int i = 0; i < MAX_ENEMY_BULLET; i++)
      if (off_screen(i_EnemyBulletPosition[i]))
        w_eb_keep[i] = 1'b0;
  end
`else
  assign w_pb_keep = '1;
  assign w_eb_keep = '1;
`endif

  aabb_overlap u_pb_ovl (
    .i_PosA    (i_PlayerBulletPosition[r_p]),
    .i_PosB    (i_EnemyPosition[r_e]),
    .i_WA      (BULLET_W),
    .i_HA      (BULLET_H),
    .i_WB      (ENEMY_W),
    .i_HB      (ENEMY_H),
    .o_Overlap (w_pb_ovl)
  );

  aabb_overlap u_eb_ovl (
    .i_PosA    (i_EnemyBulletPosition[r_b]),
    .i_PosB    (i_PlayerPosition),
    .i_WA      (BULLET_W),
    .i_HA      (BULLET_H),
    .i_WB      (PLAYER_W),
    .i_HB      (PLAYER_H),
    .o_Overlap (w_eb_ovl)
  );

  assign w_pb_last = (r_p == PW'(MAX_PLAYER_BULLET - 1)) &&
                     (r_e == EW'(MAX_ENEMY - 1));
  assign w_eb_last = (r_b == BW'(MAX_ENEMY_BULLET - 1));

  assign w_pb_hit = (r_state == S_PB_SCAN) && r_pb[r_p] &&
                    r_en[r_e] && w_pb_ovl;
  assign w_eb_hit = (r_state == S_EB_SCAN) && r_eb[r_b] &&
                    r_pl && w_eb_ovl;

  assign w_busy = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (i_fFrameTick) w_state_nxt = S_LOAD;
      S_LOAD:    w_state_nxt = S_PB_SCAN;
      S_PB_SCAN: if (w_pb_last) w_state_nxt = S_EB_SCAN;
      S_EB_SCAN: if (w_eb_last) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_en       <= '0;
      r_eb       <= '0;
      r_pb       <= '0;
      r_pl       <= 1'b0;
      r_kill     <= '0;
      r_hit      <= 1'b0;
      r_e        <= '0;
      r_p        <= '0;
      r_b        <= '0;
      r_en_out   <= '0;
      r_eb_out   <= '0;
      r_pb_out   <= '0;
      r_pl_out   <= 1'b0;
      r_kill_out <= '0;
      r_hit_pls  <= 1'b0;
      r_done_pls <= 1'b0;
      r_drop_pls <= 1'b0;
    end else begin
      r_drop_pls <= i_fFrameTick && w_busy;
      r_done_pls <= 1'b0;
      r_hit_pls  <= 1'b0;
      unique case (r_state)
        S_LOAD: begin
          r_en   <= i_EnemyState;
          r_eb   <= i_EnemyBulletState & w_eb_keep;
          r_pb   <= i_PlayerBulletState & w_pb_keep;
          r_pl   <= i_PlayerState;
          r_kill <= '0;
          r_hit  <= 1'b0;
          r_e    <= '0;
          r_p    <= '0;
          r_b    <= '0;
        end
        S_PB_SCAN: begin
          if (w_pb_hit) begin
            r_pb[r_p] <= 1'b0;
            r_en[r_e] <= 1'b0;
            r_kill    <= r_kill + KW'(1);
          end
          // Enemy index is inner; a cleared bullet still walks its row.
          if (r_e == EW'(MAX_ENEMY - 1)) begin
            r_e <= '0;
            r_p <= r_p + PW'(1);
          end else begin
            r_e <= r_e + EW'(1);
          end
        end
        S_EB_SCAN: begin
          if (w_eb_hit) begin
            r_eb[r_b] <= 1'b0;
            r_pl      <= 1'b0;
            r_hit     <= 1'b1;
          end
          r_b <= r_b + BW'(1);
          // Commit on entry to DONE, folding in the last bullet's
          // result, so outputs are valid while o_Done is high.
          if (w_eb_last) begin
            r_en_out   <= r_en;
            r_pb_out   <= r_pb;
            r_kill_out <= r_kill;
            r_eb_out   <= w_eb_hit ? (r_eb & ~(MAX_ENEMY_BULLET'(1) << r_b))
                                   : r_eb;
            r_pl_out   <= r_pl & ~w_eb_hit;
            r_hit_pls  <= r_hit | w_eb_hit;
            r_done_pls <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_EnemyState        = r_en_out;
  assign o_EnemyBulletState  = r_eb_out;
  assign o_PlayerBulletState = r_pb_out;
  assign o_PlayerState       = r_pl_out;
  assign o_KillCount         = r_kill_out;
  assign o_PlayerHit         = r_hit_pls;
  assign o_Done              = r_done_pls;
  assign o_Busy              = w_busy;
  assign o_TickDropped       = r_drop_pls;

endmodule

// File: tb/tb_bullet_collision_scan.sv
// Directed bench for bullet_collision_scan: collisions, conflict
// resolution, AABB edges, latency, tick drop, mid-scan reset, culling.
module tb_bullet_collision_scan;

  localparam int NE = 15;
  localparam int NEB = 31;
  localparam int NPB = 15;

  logic clk = 1'b0;
  logic i_Rst, i_fFrameTick, i_PlayerState;
  logic [NE-1:0]  i_EnemyState;
  logic [NEB-1:0] i_EnemyBulletState;
  logic [NPB-1:0] i_PlayerBulletState;
  logic [18:0] i_EnemyPosition [NE];
  logic [18:0] i_EnemyBulletPosition [NEB];
  logic [18:0] i_PlayerBulletPosition [NPB];
  logic [18:0] i_PlayerPosition;
  logic [NE-1:0]  o_EnemyState;
  logic [NEB-1:0] o_EnemyBulletState;
  logic [NPB-1:0] o_PlayerBulletState;
  logic o_PlayerState, o_PlayerHit, o_Busy, o_Done, o_TickDropped;
  logic [3:0] o_KillCount;

  int total = 0;
  int bad = 0;
  int lat, ndone, nhit;
  logic [NPB-1:0] exp_pb_a;

  always #5 clk = ~clk;

  bullet_collision_scan dut (
    .i_Clk                  (clk),
    .i_Rst                  (i_Rst),
    .i_fFrameTick           (i_fFrameTick),
    .i_EnemyState           (i_EnemyState),
    .i_EnemyBulletState     (i_EnemyBulletState),
    .i_PlayerState          (i_PlayerState),
    .i_PlayerBulletState    (i_PlayerBulletState),
    .i_EnemyPosition        (i_EnemyPosition),
    .i_EnemyBulletPosition  (i_EnemyBulletPosition),
    .i_PlayerBulletPosition (i_PlayerBulletPosition),
    .i_PlayerPosition       (i_PlayerPosition),
    .o_EnemyState           (o_EnemyState),
    .o_EnemyBulletState     (o_EnemyBulletState),
    .o_PlayerBulletState    (o_PlayerBulletState),
    .o_PlayerState          (o_PlayerState),
    .o_KillCount            (o_KillCount),
    .o_PlayerHit            (o_PlayerHit),
    .o_Busy                 (o_Busy),
    .o_Done                 (o_Done),
    .o_TickDropped          (o_TickDropped)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] pos(input int x, input int y);
    return {10'(x), 9'(y)};
  endfunction

  task automatic clr_in();
    i_EnemyState = '0;
    i_EnemyBulletState = '0;
    i_PlayerBulletState = '0;
    i_PlayerState = 1'b0;
    i_PlayerPosition = '0;
    for (int i = 0; i < NE; i++) i_EnemyPosition[i] = '0;
    for (int i = 0; i < NEB; i++) i_EnemyBulletPosition[i] = '0;
    for (int i = 0; i < NPB; i++) i_PlayerBulletPosition[i] = '0;
  endtask

  // Frame A: single kill, AABB edge cases, one enemy-bullet hit,
  // and an underflowed player bullet at y=511.
  task automatic setup_a();
    clr_in();
    i_EnemyState[0] = 1'b1;
    i_EnemyPosition[0] = pos(90, 90);
    i_PlayerBulletState[0] = 1'b1;
    i_PlayerBulletPosition[0] = pos(100, 100);
    i_PlayerBulletState[4] = 1'b1;
    i_PlayerBulletPosition[4] = pos(50, 511);
    i_PlayerState = 1'b1;
    i_PlayerPosition = pos(300, 400);
    i_EnemyBulletState[9] = 1'b1;
    i_EnemyBulletPosition[9] = pos(320, 400);
    i_EnemyBulletState[10] = 1'b1;
    i_EnemyBulletPosition[10] = pos(296, 400);
    i_EnemyBulletState[11] = 1'b1;
    i_EnemyBulletPosition[11] = pos(300, 424);
    i_EnemyBulletState[12] = 1'b1;
    i_EnemyBulletPosition[12] = pos(316, 417);
  endtask

  // Frame B: two bullets on enemy 3, one bullet over enemies 6 and 7,
  // enemy bullets 2 and 5 on the player.
  task automatic setup_b();
    clr_in();
    i_EnemyState[3] = 1'b1;
    i_EnemyPosition[3] = pos(190, 40);
    i_EnemyState[6] = 1'b1;
    i_EnemyPosition[6] = pos(390, 190);
    i_EnemyState[7] = 1'b1;
    i_EnemyPosition[7] = pos(395, 195);
    i_PlayerBulletState[0] = 1'b1;
    i_PlayerBulletPosition[0] = pos(200, 50);
    i_PlayerBulletState[1] = 1'b1;
    i_PlayerBulletPosition[1] = pos(205, 50);
    i_PlayerBulletState[2] = 1'b1;
    i_PlayerBulletPosition[2] = pos(400, 200);
    i_PlayerState = 1'b1;
    i_PlayerPosition = pos(300, 400);
    i_EnemyBulletState[2] = 1'b1;
    i_EnemyBulletPosition[2] = pos(305, 405);
    i_EnemyBulletState[5] = 1'b1;
    i_EnemyBulletPosition[5] = pos(310, 410);
    i_EnemyBulletState[7] = 1'b1;
    i_EnemyBulletPosition[7] = pos(100, 100);
  endtask

  // Tick sampled at edge k; c counts edges after k. o_Done is visible
  // #1 after edge k+257. d1/d2: extra tick at edge k+d; rt: tick at
  // edge k+rt expected to start a new frame; rs: reset at edge k+rs.
  task automatic run_frame(input int d1, input int d2, input int rt,
                           input int rs);
    i_fFrameTick = 1'b1;
    @(posedge clk); #1;
    i_fFrameTick = 1'b0;
    lat = -1;
    ndone = 0;
    nhit = 0;
    for (int c = 1; c <= 300; c++) begin
      if (c == d1 || c == d2 || c == rt) i_fFrameTick = 1'b1;
      if (c == rs) i_Rst = 1'b1;
      @(posedge clk); #1;
      if (c == d1 || c == d2) begin
        i_fFrameTick = 1'b0;
        chk("tick_dropped", o_TickDropped, 1'b1);
      end
      if (c == rt) begin
        i_fFrameTick = 1'b0;
        chk("retick_busy", o_Busy, 1'b1);
        chk("retick_nodrop", o_TickDropped, 1'b0);
      end
      if (c == rs) begin
        i_Rst = 1'b0;
        chk("rst_busy", o_Busy, 1'b0);
        chk("rst_en", o_EnemyState, '0);
        chk("rst_eb", o_EnemyBulletState, '0);
        chk("rst_pb", o_PlayerBulletState, '0);
        chk("rst_pl", o_PlayerState, 1'b0);
        chk("rst_kill", o_KillCount, '0);
        break;
      end
      if (c == 200) chk("busy_mid", o_Busy, 1'b1);
      if (o_Done) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      if (o_PlayerHit) nhit++;
      if (lat > 0 && c == lat) chk("busy_in_done", o_Busy, 1'b1);
      if (lat > 0 && c == lat + 1 && rt == 0)
        chk("idle_after_done", o_Busy, 1'b0);
    end
  endtask

  task automatic check_a(input string t);
    chk({t, "_en"}, o_EnemyState, 15'h0000);
    chk({t, "_pb"}, o_PlayerBulletState, exp_pb_a);
    chk({t, "_kill"}, o_KillCount, 4'd1);
    chk({t, "_pl"}, o_PlayerState, 1'b0);
    chk({t, "_eb"}, o_EnemyBulletState, 31'h0000_0E00);
  endtask

  task automatic check_b(input string t);
    chk({t, "_en"}, o_EnemyState, 15'h0080);
    chk({t, "_pb"}, o_PlayerBulletState, 15'h0002);
    chk({t, "_kill"}, o_KillCount, 4'd2);
    chk({t, "_pl"}, o_PlayerState, 1'b0);
    chk({t, "_eb"}, o_EnemyBulletState, 31'h0000_00A0);
  endtask

  initial begin
`ifdef BULLET_CULL_EN
    exp_pb_a = 15'h0000;
`else
    exp_pb_a = 15'h0010;
`endif
    i_Rst = 1'b1;
    i_fFrameTick = 1'b0;
    clr_in();
    repeat (3) @(posedge clk);
    #1;
    i_Rst = 1'b0;
    chk("reset_busy", o_Busy, 1'b0);
    chk("reset_done", o_Done, 1'b0);
    chk("reset_hit", o_PlayerHit, 1'b0);
    chk("reset_drop", o_TickDropped, 1'b0);
    chk("reset_en", o_EnemyState, '0);
    chk("reset_kill", o_KillCount, '0);

    setup_a();
    run_frame(0, 0, 0, 0);
    chk("a_latency", lat, 257);
    chk("a_ndone", ndone, 1);
    chk("a_nhit", nhit, 1);
    check_a("a");

    setup_b();
    run_frame(50, 258, 259, 0);
    chk("b_latency", lat, 257);
    chk("b_ndone", ndone, 1);
    chk("b_nhit", nhit, 1);
    check_b("b_hold");
    repeat (260) @(posedge clk);
    #1;
    chk("b2_idle", o_Busy, 1'b0);
    check_b("b2");

    setup_a();
    run_frame(0, 0, 0, 100);
    chk("rst_ndone", ndone, 0);
    @(posedge clk); #1;
    chk("rst_still_idle", o_Busy, 1'b0);

    run_frame(0, 0, 0, 0);
    chk("post_rst_latency", lat, 257);
    chk("post_rst_ndone", ndone, 1);
    check_a("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
